seq_det_sched: RTL
==================

// Module: seq_det_sched
// PURPOSE
//  Shares one bit-serial Mealy sequence detector (1011, overlapping) between two byte-stream requesters.
//  Arbitrates round-robin, clears the detector, then shifts the granted word MSB-first into it.
//  Counts detector hits over the word and returns the count with a valid/ready response.
//  Sits between the requester ports and the detector instance.
// PARAMETERS
//  DATA_W  8  width of each request word = number of bits shifted per job
//  CNT_W   4  width of hit counter / rsp_count; saturates at 2**CNT_W-1
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   2       per-requester request; must hold with data until accepted
//  req_data0  in   DATA_W  requester 0 word
//  req_data1  in   DATA_W  requester 1 word
//  req_ready  out  2       one-hot accept strobe; handshake when valid&ready
//  det_bit    out  1       serial bit to detector 'in'
//  det_clr    out  1       active-high detector clear (board inverts for active-low rst)
//  det_hit    in   1       detector 'out' (combinational Mealy output for current det_bit)
//  rsp_valid  out  1       result available; held until rsp_ready
//  rsp_id     out  1       requester index of this result
//  rsp_count  out  CNT_W   number of hits over the word
//  rsp_ready  in   1       consumer accepts result
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, rr_ptr=0, shreg=0, bit_cnt=0, hit_cnt=0, rsp_id=0.
//   While rst=1: det_clr=1; req_ready=0, rsp_valid=0, det_bit=0 (all outputs reset within the same cycle).
//  FSM: IDLE -> CLR -> SHIFT -> RESP -> IDLE.
//  IDLE: grant = valid requester; if both valid, the requester at rr_ptr wins.
//   req_ready[grant]=1 combinationally in that cycle; at the edge load shreg<=req_dataN, rsp_id<=grant,
//   hit_cnt<=0, rr_ptr<=~grant, go CLR. Nothing is valid -> stay in IDLE, req_ready=0.
//  CLR: exactly one cycle, det_clr=1, det_bit=0, go SHIFT with bit_cnt=0.
//  SHIFT: det_bit=shreg[DATA_W-1]; each cycle sample det_hit in the same cycle;
//   if det_hit, hit_cnt<=hit_cnt+1 saturating at all-ones (no wrap).
//   shreg<=shreg<<1, bit_cnt++; after DATA_W cycles (bit_cnt==DATA_W-1), go RESP.
//  RESP: rsp_valid=1, rsp_count=hit_cnt, rsp_id stable; leave only on rsp_ready=1 -> IDLE.
//   Backpressure: hold indefinitely; no new grant while in RESP.
//  Latency: accept in cycle 0 -> CLR in cycle 1 -> SHIFT cycles 2..DATA_W+1 -> rsp_valid first high in cycle DATA_W+2.
//   Min job period DATA_W+3 cycles, because one IDLE cycle follows each response.
//  det_clr=0 and det_bit=0 outside CLR/SHIFT, except during reset.
//  Fairness: both requesters continuously valid -> strict alternation 0,1,0,1...
//  A lone requester is served back-to-back regardless of rr_ptr.
//  req_valid changes outside IDLE are ignored; the loaded word is unaffected.
//  Reset mid-job: abort immediately, no response emitted, rr_ptr returns to 0.
//  Illegal state encodings recover to IDLE.
// TESTING
//  T1 reset: rst high 2 cycles mid-SHIFT -> next cycle IDLE, rsp_valid=0, det_clr=1 during rst, no response.
//  T2 single job: req0 data=8'b1011_1011, rsp_ready=1 -> rsp_valid at cycle 10 after accept, id=0, count=2.
//  T3 overlap: req1 data=8'b1011_0110 -> id=1, count=2; data=8'h00 -> count=0; 8'hFF -> count=0.
//  T4 contention: both valid continuously, data0=8'hBB, data1=8'h00 -> responses alternate id 0,1,0,1 with counts 2,0,2,0.
//  T5 backpressure: hold rsp_ready=0 for 20 cycles -> rsp_valid/id/count stable, req_ready stays 0, both requests waiting.
//  T6 saturation: CNT_W=1, data=8'b1011_1011 -> count=1 (saturated, no wrap to 0).

Source files
------------

// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin sharing of one serial 1011 Mealy detector between two word requesters
module seq_det_sched #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic              det_bit,
    output logic              det_clr,
    input  logic              det_hit,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [CNT_W-1:0]  rsp_count,
    input  logic              rsp_ready
);
    localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, RESP} state_t;

    state_t            state, state_nx;
    logic              rr_ptr;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [CNT_W-1:0]  hit_cnt;
    logic              any_req, gnt, last_bit;

    assign any_req  = |req_valid;
    assign gnt      = &req_valid ? rr_ptr : req_valid[1];
    assign last_bit = bit_cnt == BW'(DATA_W - 1);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state: one clear cycle, DATA_W shift cycles, then hold the response until taken
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = any_req ? CLR : IDLE;
            CLR:     state_nx = SHIFT;
            SHIFT:   state_nx = last_bit ? RESP : SHIFT;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // outputs: reset forces the detector into clear and silences both handshakes at once
    always_comb begin
        req_ready = (!rst && state == IDLE && any_req) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        det_clr   = rst || state == CLR;
        det_bit   = !rst && state == SHIFT && shreg[DATA_W-1];
        rsp_valid = !rst && state == RESP;
        rsp_count = hit_cnt;
    end

    // datapath: load the granted word, shift it MSB-first and count saturating hits
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            hit_cnt <= '0;
            rsp_id  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    shreg   <= gnt ? req_data1 : req_data0;
                    rsp_id  <= gnt;
                    hit_cnt <= '0;
                    rr_ptr  <= ~gnt;
                end
                CLR: bit_cnt <= '0;
                SHIFT: begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + BW'(1);
                    if (det_hit && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
